// File: rtl/sisc_fetch_unit.sv
// SISC fetch stage: fetch PC, single-outstanding instruction-memory reads,
// and a DEPTH-entry prefetch FIFO presented to decode with valid/ready.
module sisc_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_f,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_rvalid,
  input  logic [INSTR_W-1:0]     mem_rdata,
  input  logic                   br_taken,
  input  logic [ADDR_W-1:0]      br_addr,
  input  logic                   halt,
  output logic                   ir_valid,
  output logic [INSTR_W-1:0]     ir,
  output logic [ADDR_W-1:0]      ir_pc,
  input  logic                   ir_ready,
  output logic [$clog2(DEPTH):0] buf_count
);

  localparam int              PW   = $clog2(DEPTH);
  localparam int              CW   = PW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0]  addr_q  [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  logic               outstanding;
  logic               can_issue;
  logic               can_chain;
  logic               push;
  logic               pop;
  logic [PW-1:0]      rd_ptr_nxt;
  logic [CW-1:0]      count_after_pop;
  logic [CW-1:0]      count_nxt;

  assign ir_valid = (buf_count != '0);

  // Issue and FIFO bookkeeping from pre-edge registered state only
  always_comb begin
    outstanding     = (state != IDLE);
    can_issue       = ((buf_count + CW'(outstanding)) < FULL) && !halt && !br_taken;
    can_chain       = ((buf_count + CW'(1)) < FULL) && !halt;
    push            = (state == WAIT) && mem_rvalid && !br_taken;
    pop             = ir_valid && ir_ready && !br_taken;
    rd_ptr_nxt      = rd_ptr + PW'(pop);
    count_after_pop = buf_count - CW'(pop);
    count_nxt       = count_after_pop + CW'(push);
  end

  // FIFO storage: data only, pointers decide what is live
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= mem_rdata;
      addr_q[wr_ptr]  <= mem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= RESET_PC;
      pc        <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
      ir        <= '0;
      ir_pc     <= '0;
    end else if (br_taken) begin
      pc        <= br_addr;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
      // A request still in flight must be absorbed before the new fetch starts
      if (outstanding && !mem_rvalid) begin
        state <= DISCARD;
      end else begin
        state   <= IDLE;
        mem_req <= 1'b0;
      end
    end else begin
      buf_count <= count_nxt;
      rd_ptr    <= rd_ptr_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);

      // Head register: bypass the pushed word when the FIFO would otherwise be empty
      if (count_after_pop == '0) begin
        if (push) begin
          ir    <= mem_rdata;
          ir_pc <= mem_addr;
        end
      end else begin
        ir    <= instr_q[rd_ptr_nxt];
        ir_pc <= addr_q[rd_ptr_nxt];
      end

      case (state)
        IDLE: begin
          if (can_issue) begin
            state    <= WAIT;
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            pc <= pc + ADDR_W'(1);
            if (can_chain) begin
              mem_addr <= pc + ADDR_W'(1);
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (mem_rvalid) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit: memory model answers in the 2nd cycle
// of each request; a second instance starts near the top of the address space.
module tb_sisc_fetch_unit;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic               clk;
  logic               rst_f;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rvalid = 1'b0;
  logic [INSTR_W-1:0] mem_rdata  = '0;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_addr;
  logic               halt;
  logic               ir_valid;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_ready;
  logic [CW-1:0]      buf_count;

  logic               mem_req_b;
  logic [ADDR_W-1:0]  mem_addr_b;
  logic               mem_rvalid_b = 1'b0;
  logic [INSTR_W-1:0] mem_rdata_b  = '0;
  logic               br_taken_b;
  logic [ADDR_W-1:0]  br_addr_b;
  logic               halt_b;
  logic               ir_valid_b;
  logic [INSTR_W-1:0] ir_b;
  logic [ADDR_W-1:0]  ir_pc_b;
  logic               ir_ready_b;
  logic [CW-1:0]      buf_count_b;

  sisc_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_f(rst_f), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .br_taken(br_taken),
    .br_addr(br_addr), .halt(halt), .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc),
    .ir_ready(ir_ready), .buf_count(buf_count)
  );

  sisc_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut_b (
    .clk(clk), .rst_f(rst_f), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
    .mem_rvalid(mem_rvalid_b), .mem_rdata(mem_rdata_b), .br_taken(br_taken_b),
    .br_addr(br_addr_b), .halt(halt_b), .ir_valid(ir_valid_b), .ir(ir_b), .ir_pc(ir_pc_b),
    .ir_ready(ir_ready_b), .buf_count(buf_count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int age_a = 0;
  int age_b = 0;

  // Memory models: rvalid in the 2nd cycle of every request
  always @(negedge clk) begin
    if (!mem_req) begin
      age_a = 0;
      mem_rvalid = 1'b0;
    end else begin
      if (mem_rvalid) age_a = 0;
      age_a = age_a + 1;
      mem_rvalid = (age_a == 2);
    end
    mem_rdata = 32'hA000_0000 + {16'h0000, mem_addr};
  end

  always @(negedge clk) begin
    if (!mem_req_b) begin
      age_b = 0;
      mem_rvalid_b = 1'b0;
    end else begin
      if (mem_rvalid_b) age_b = 0;
      age_b = age_b + 1;
      mem_rvalid_b = (age_b == 2);
    end
    mem_rdata_b = 32'hB000_0000 + {16'h0000, mem_addr_b};
  end

  int                n_done_a = 0;
  logic              ovf_seen = 1'b0;
  int                max_cnt  = 0;
  logic [ADDR_W-1:0] q_b[$];

  always @(posedge clk) begin
    if (!rst_f && mem_req && mem_rvalid) n_done_a <= n_done_a + 1;
    if (!rst_f && mem_req && mem_rvalid && !br_taken && buf_count == CW'(DEPTH)) ovf_seen <= 1'b1;
    if (!rst_f && mem_req_b && mem_rvalid_b && buf_count_b == CW'(DEPTH)) ovf_seen <= 1'b1;
    if (int'(buf_count) > max_cnt) max_cnt <= int'(buf_count);
    if (int'(buf_count_b) > max_cnt) max_cnt <= int'(buf_count_b);
    if (!rst_f && mem_req_b && mem_rvalid_b && q_b.size() < 8) q_b.push_back(mem_addr_b);
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_f    = 1'b1;
    br_taken = 1'b0;
    halt     = 1'b0;
    ir_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_f = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   got;
    int   base;
    logic found;
    logic [ADDR_W-1:0] exp4 [4];
    exp4 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    rst_f      = 1'b1;
    br_taken   = 1'b0;
    br_addr    = '0;
    halt       = 1'b0;
    ir_ready   = 1'b0;
    br_taken_b = 1'b0;
    br_addr_b  = '0;
    halt_b     = 1'b0;
    ir_ready_b = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_mem_req",   64'(mem_req),   64'h0);
    chk("rst_mem_addr",  64'(mem_addr),  64'h0);
    chk("rst_ir_valid",  64'(ir_valid),  64'h0);
    chk("rst_ir",        64'(ir),        64'h0);
    chk("rst_ir_pc",     64'(ir_pc),     64'h0);
    chk("rst_buf_count", 64'(buf_count), 64'h0);
    chk("rst_b_addr",    64'(mem_addr_b), 64'hFFFE);

    // Streaming with decode always ready
    rst_f    = 1'b0;
    ir_ready = 1'b1;
    got      = 0;
    for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
      @(negedge clk);
      chk("t1_req_held", 64'(mem_req), 64'h1);
      if (ir_valid) begin
        chk("t1_ir",    64'(ir),    64'(32'hA000_0000 + got));
        chk("t1_ir_pc", 64'(ir_pc), 64'(got));
        got++;
      end
    end
    chk("t1_received", 64'(got), 64'd6);

    // Wrap-around of the second instance's fetch PC
    chk("t4_nreq", 64'(q_b.size() >= 4), 64'h1);
    for (int i = 0; i < 4; i++) chk("t4_addr", 64'(q_b[i]), 64'(exp4[i]));

    // Fill the FIFO with decode stalled
    do_reset();
    base = n_done_a;
    repeat (14) @(negedge clk);
    chk("t2_req_low",  64'(mem_req),   64'h0);
    chk("t2_full",     64'(buf_count), 64'd4);
    chk("t2_nreq",     64'(n_done_a - base), 64'd4);
    chk("t2_ir",       64'(ir),        64'hA000_0000);
    chk("t2_ir_pc",    64'(ir_pc),     64'h0);
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    chk("t2_pop_cnt",  64'(buf_count), 64'd3);
    chk("t2_pop_req",  64'(mem_req),   64'h0);
    chk("t2_pop_pc",   64'(ir_pc),     64'h1);
    chk("t2_pop_ir",   64'(ir),        64'hA000_0001);
    @(negedge clk);
    chk("t2_refill_req",  64'(mem_req),  64'h1);
    chk("t2_refill_addr", 64'(mem_addr), 64'h4);
    repeat (4) @(negedge clk);
    chk("t2_refull",   64'(buf_count), 64'd4);
    chk("t2_idle",     64'(mem_req),   64'h0);
    chk("t2_nreq5",    64'(n_done_a - base), 64'd5);

    // Redirect while the request to address 2 is outstanding
    do_reset();
    repeat (5) @(negedge clk);
    chk("t3_pre_req",  64'(mem_req),   64'h1);
    chk("t3_pre_addr", 64'(mem_addr),  64'h2);
    chk("t3_pre_cnt",  64'(buf_count), 64'd2);
    br_taken = 1'b1;
    br_addr  = 16'h0040;
    @(negedge clk);
    br_taken = 1'b0;
    chk("t3_flush_valid", 64'(ir_valid),  64'h0);
    chk("t3_flush_cnt",   64'(buf_count), 64'h0);
    chk("t3_hold_req",    64'(mem_req),   64'h1);
    chk("t3_hold_addr",   64'(mem_addr),  64'h2);
    @(negedge clk);
    chk("t3_drop_req",    64'(mem_req),   64'h0);
    chk("t3_drop_cnt",    64'(buf_count), 64'h0);
    @(negedge clk);
    chk("t3_new_req",     64'(mem_req),   64'h1);
    chk("t3_new_addr",    64'(mem_addr),  64'h40);
    ir_ready = 1'b1;
    found = 1'b0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      @(negedge clk);
      if (ir_valid) begin
        found = 1'b1;
        chk("t3_first_pc", 64'(ir_pc), 64'h40);
        chk("t3_first_ir", 64'(ir),    64'hA000_0040);
      end
    end
    chk("t3_found", 64'(found), 64'h1);

    // Halt with one request outstanding
    do_reset();
    repeat (3) @(negedge clk);
    chk("t5_pre_req",  64'(mem_req),   64'h1);
    chk("t5_pre_addr", 64'(mem_addr),  64'h1);
    chk("t5_pre_cnt",  64'(buf_count), 64'd1);
    halt = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_halt_req", 64'(mem_req),   64'h0);
    chk("t5_halt_cnt", 64'(buf_count), 64'd2);
    chk("t5_halt_pc",  64'(ir_pc),     64'h0);
    ir_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      chk("t5_no_req", 64'(mem_req), 64'h0);
    end
    chk("t5_drained",  64'(buf_count), 64'h0);
    chk("t5_empty",    64'(ir_valid),  64'h0);
    halt = 1'b0;
    @(negedge clk);
    chk("t5_resume_req",  64'(mem_req),  64'h1);
    chk("t5_resume_addr", 64'(mem_addr), 64'h2);

    // Reset while a request is outstanding and rvalid is high
    do_reset();
    repeat (6) @(negedge clk);
    chk("t6_pre_cnt",  64'(buf_count), 64'd2);
    chk("t6_pre_req",  64'(mem_req),   64'h1);
    chk("t6_pre_addr", 64'(mem_addr),  64'h2);
    rst_f = 1'b1;
    @(negedge clk);
    chk("t6_mem_req",   64'(mem_req),   64'h0);
    chk("t6_mem_addr",  64'(mem_addr),  64'h0);
    chk("t6_ir_valid",  64'(ir_valid),  64'h0);
    chk("t6_ir",        64'(ir),        64'h0);
    chk("t6_ir_pc",     64'(ir_pc),     64'h0);
    chk("t6_buf_count", 64'(buf_count), 64'h0);
    rst_f = 1'b0;
    @(negedge clk);
    chk("t6_first_req",  64'(mem_req),  64'h1);
    chk("t6_first_addr", 64'(mem_addr), 64'h0);

    chk("no_overflow", 64'(ovf_seen),       64'h0);
    chk("max_count",   64'(max_cnt <= DEPTH), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sisc_fetch_unit.md
Name: sisc_fetch_unit

Overview:
- Parametrised fetch stage for the next-generation SISC core. Replaces the fixed pc/im/ir trio with a single block.
- Holds the fetch PC and issues word reads to instruction memory over a req/rvalid handshake, one request outstanding at a time.
- Buffers returned instructions in a DEPTH-entry prefetch FIFO and presents them to decode with a valid/ready handshake.
- Flushes on a branch redirect.

Parameters:
- ADDR_W, 16, width of word addresses, fetch PC and branch target.
- INSTR_W, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries. Must be a power of 2 and at least 2.
- RESET_PC, 0, fetch PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_f  input  1  reset; synchronous, active-high.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  ADDR_W  word address of the request.
- mem_rvalid  input  1  read data valid; completes the outstanding request.
- mem_rdata  input  INSTR_W  instruction word returned by memory.
- br_taken  input  1  redirect strobe from the branch/ctrl logic.
- br_addr  input  ADDR_W  redirect target.
- halt  input  1  suppresses new requests while high.
- ir_valid  output  1  FIFO head is valid.
- ir  output  INSTR_W  FIFO head instruction.
- ir_pc  output  ADDR_W  address of the FIFO head instruction.
- ir_ready  input  1  decode accepts the head this cycle.
- buf_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_f=1 at a clock edge):
  - Outputs: mem_req=0, mem_addr=RESET_PC, ir_valid=0, ir=0, ir_pc=0, buf_count=0.
  - Internal: fetch PC=RESET_PC, state=IDLE, FIFO pointers=0.
  - Reset overrides every other input, including while a request is outstanding. Any rvalid in the reset cycle is dropped.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its response will be kept.
  - DISCARD: request outstanding; its response will be dropped because of a redirect.
- Issue condition: (buf_count + outstanding) < DEPTH, halt=0, br_taken=0.
  - outstanding = 1 in WAIT or DISCARD, else 0.
  - Counts used are the pre-edge registered values; there is no look-ahead on a same-cycle pop.
- IDLE -> WAIT when the issue condition holds. mem_req rises the next cycle with mem_addr = fetch PC.
- Request protocol:
  - Once mem_req is high, it and mem_addr hold stable until a cycle with mem_rvalid=1.
  - mem_rvalid while mem_req=0 is ignored.
- WAIT with mem_rvalid=1:
  - Push {mem_rdata, mem_addr} into the FIFO.
  - fetch PC <= fetch PC + 1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000 at the default width).
  - If the issue condition still holds after the push (count+1 < DEPTH, no halt): stay in WAIT and present the next address (back-to-back).
  - Otherwise go to IDLE and drop mem_req.
- Redirect (br_taken=1, highest priority after reset):
  - FIFO flushed: buf_count=0 and ir_valid=0 from the next cycle.
  - A same-cycle pop is ignored.
  - fetch PC <= br_addr.
  - WAIT without rvalid -> DISCARD. mem_req stays high with the old address.
  - WAIT with rvalid, or DISCARD with rvalid -> IDLE; the returned data is dropped.
  - IDLE -> IDLE. The first request to br_addr issues no earlier than the cycle after the redirect.
- DISCARD with mem_rvalid=1: drop the data and go to IDLE. The new fetch starts per the issue condition.
- Repeated redirects: the latest br_addr wins.
- FIFO output:
  - ir_valid = (buf_count != 0).
  - ir and ir_pc show the head entry, registered from FIFO storage.
  - Pop when ir_valid and ir_ready. ir_ready while empty has no effect.
  - Push and pop in the same cycle: buf_count unchanged.
  - Overflow cannot occur by construction. Any push when full is an assertion failure in the bench.
- halt=1:
  - No new issue.
  - An outstanding request still completes and pushes.
  - The FIFO keeps draining to decode.
  - Redirects are still honoured.

Test Plan:
1. Reset, then a memory model returning mem_rdata=0xA000_0000+addr with rvalid in the 2nd cycle of each request, ir_ready=1 -> addresses 0,1,2,3... issued back-to-back; ir/ir_pc sequence (0xA0000000,0),(0xA0000001,1)...; buf_count never exceeds DEPTH=4.
2. ir_ready=0 throughout -> exactly 4 requests issued (addr 0..3); mem_req low afterwards; buf_count=4. Raise ir_ready for one cycle -> count 3, then one new request to addr 4.
3. br_taken with br_addr=0x0040 while a request to addr 2 is outstanding -> next cycle ir_valid=0, buf_count=0; addr 2 data dropped; next mem_addr=0x0040; ir_pc of the first valid output=0x0040.
4. Start with RESET_PC=0xFFFE, ADDR_W=16 -> fetch addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
5. halt=1 mid-stream with one request outstanding -> that response pushed, no further mem_req, FIFO drains to 0; deassert halt -> issue resumes at the next sequential address.
6. rst_f=1 while in WAIT with 2 buffered entries -> next cycle all reset values, mem_req=0; after release, first mem_addr=RESET_PC.
